tdc_hit_capture: RTL
====================

# tdc_hit_capture

Front-end capture stage of the SPAD TDC. Samples the 32-bit delay-line tap word and a hit strobe through a two-flop synchroniser and detects the hit rising edge. It then stamps the event with a free-running coarse counter and queues {coarse, taps} in a small first-word-fall-through FIFO. The FIFO head tap word drives the thermometer-to-binary decode stage, which yields the 5-bit fine time.

## Interface
- COARSE_W, 16, coarse counter width (2..32)
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16
- clk  input  1  sole clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- en  input  1  capture enable; low clears counter and blocks capture
- hit  input  1  asynchronous SPAD hit strobe (level, active-high)
- tap_in  input  32  asynchronous delay-line tap word; bit 31 = phase, bits 30:0 thermometer run
- out_ready  input  1  consumer accepts head entry
- ovf_clr  input  1  clears overflow flag
- out_valid  output  1  FIFO non-empty
- out_coarse  output  COARSE_W  coarse stamp of head entry
- out_taps  output  32  tap word of head entry, to decode stage
- overflow  output  1  sticky: a hit was dropped because FIFO full
- cnt_wrap  output  1  one-cycle pulse when coarse counter wraps

## Operation
- Sync pipeline, every edge, unconditional: hit_s1<=hit, tap_s1<=tap_in; hit_s2<=hit_s1, tap_s2<=tap_s1; hit_s3<=hit_s2.
- rise = hit_s2 & ~hit_s3 & en. Level hits produce exactly one event per rising edge.
- Coarse counter: en=1 → +1 per cycle, wraps 2^COARSE_W-1 → 0, cnt_wrap=1 during the cycle after the wrap edge (counter == 0 from wrap). en=0 → counter forced to 0 at next edge, cnt_wrap=0.
- On rise: at next edge write {counter value during rise cycle, fix(tap_s2)} into FIFO if not full.
- fix(): see Configuration; bit 31 always passed raw.
- Pop: out_valid & out_ready at an edge removes head.
- Full and rise with no pop: entry dropped, overflow<=1. Full and rise with pop in same cycle: push accepted, occupancy unchanged, no overflow.
- Empty and rise: entry visible on out_* after write edge (fall-through; no bypass in the same cycle).
- overflow cleared by ovf_clr at next edge; if a drop and ovf_clr coincide, overflow stays 1.
- en=0: FIFO keeps contents and still drains; no new pushes.
- rst_n=0 at any edge: sync flops, counter, FIFO pointers, occupancy cleared. Any in-flight hit is lost; queued entries are discarded.

## Timing
- Reset values: out_valid=0, out_coarse=0, out_taps=0, overflow=0, cnt_wrap=0. The s1/s2/s3 registers are 0.
- hit high sampled at edge E0 → rise during cycle after E1 → FIFO write at E2 → out_valid=1 after E2. Latency from E0 is 3 edges.
- Stored taps = tap_in sampled at E0. Stored coarse = counter value between E1 and E2.
- Minimum hit spacing for separate events: hit low for at least one sampled edge between highs.
- Pop-to-next-head: out_* show next entry in cycle after pop edge; out_valid falls in same cycle when last entry popped.
- out_* hold last head value when empty (no X, 0 after reset).
- Sustained throughput: one push and one pop per cycle.

## Configuration
- BUBBLE_FIX_EN defined: fix() is applied to tap_s2[30:0]. Bit i becomes majority(tap[i-1], tap[i], tap[i+1]) for 1≤i≤29. Bits 0 and 30 pass raw. This removes single-bit bubbles, so the decode stage receives a legal code.
- Undefined: fix() is identity; raw tap_s2 stored. Adds no logic and no latency.
- Latency is identical in both builds (correction is combinational before the FIFO write).

## Test plan
- Reset, en=1, hit=0 for 70000 cycles, COARSE_W=16 → cnt_wrap pulses once after 65536 counts; out_valid stays 0.
- en=1, counter=100 at E0; hit 0→1 with tap_in=32'h7FFF_0000 at E0 → out_valid=1 after E2, out_coarse=102, out_taps=32'h7FFF_0000.
- With BUBBLE_FIX_EN, tap_in=32'h7FFB_0000 (single bubble at bit 18) → out_taps=32'h7FFF_0000. Without the macro → out_taps=32'h7FFB_0000.
- out_ready=0, five separate hits, FIFO_DEPTH=4 → 4 entries held, overflow=1. ovf_clr pulse → overflow=0. Pops return 4 entries in order, then out_valid=0.
- FIFO full, out_ready=1 and a rise in the same cycle → occupancy stays 4, overflow stays 0, new entry appears last.
- Hit pending (sampled at E0), rst_n=0 at E1 → no entry appears, all outputs 0. en=0 with a hit → no entry, counter held at 0.

Source files
------------

// File: rtl/tdc_hit_capture.sv
// tdc_hit_capture: synchronises SPAD hit/taps, stamps rising edges with a coarse count, queues them in a FWFT FIFO.
// Optional BUBBLE_FIX_EN applies a 3-tap majority filter to tap bits 29:1 before the FIFO write.
module tdc_hit_capture #(
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                hit_i,
    input  logic [31:0]         tap_in_i,
    input  logic                out_ready_i,
    input  logic                ovf_clr_i,
    output logic                out_valid_o,
    output logic [COARSE_W-1:0] out_coarse_o,
    output logic [31:0]         out_taps_o,
    output logic                overflow_o,
    output logic                cnt_wrap_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = COARSE_W + 32;

    logic                hit_s1_q, hit_s2_q, hit_s3_q;
    logic [31:0]         tap_s1_q, tap_s2_q, tap_fix;
    logic [COARSE_W-1:0] cnt_q, cnt_d;
    logic                wrap_q, wrap_d, ovf_q, ovf_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [EW-1:0]       last_q, last_d;
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]         occ_q, occ_d;
    logic                rise, full, pop, push;

`ifdef BUBBLE_FIX_EN
    always_comb begin
        tap_fix = tap_s2_q;
        for (int i = 1; i < 30; i++)
            tap_fix[i] = (tap_s2_q[i-1] & tap_s2_q[i]) | (tap_s2_q[i-1] & tap_s2_q[i+1]) | (tap_s2_q[i] & tap_s2_q[i+1]);
    end
`else
    assign tap_fix = tap_s2_q;
`endif

    always_comb begin
        rise   = hit_s2_q & ~hit_s3_q & en_i;
        full   = occ_q == (AW+1)'(FIFO_DEPTH);
        pop    = (occ_q != '0) & out_ready_i;
        // a pop in the same cycle frees the slot, so a full FIFO can still take the push
        push   = rise & (~full | pop);
        cnt_d  = en_i ? cnt_q + COARSE_W'(1) : '0;
        wrap_d = en_i & (&cnt_q);
        ovf_d  = (rise & full & ~pop) | (ovf_q & ~ovf_clr_i);
        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        occ_d  = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        last_d = pop ? mem_q[rd_q] : last_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hit_s1_q <= 1'b0;
            hit_s2_q <= 1'b0;
            hit_s3_q <= 1'b0;
            tap_s1_q <= '0;
            tap_s2_q <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            last_q   <= '0;
        end else begin
            hit_s1_q <= hit_i;
            hit_s2_q <= hit_s1_q;
            hit_s3_q <= hit_s2_q;
            tap_s1_q <= tap_in_i;
            tap_s2_q <= tap_s1_q;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && push)
            mem_q[wr_q] <= {cnt_q, tap_fix};
    end

    // when empty, show the most recently popped entry instead of a stale slot
    assign out_valid_o = occ_q != '0;
    assign {out_coarse_o, out_taps_o} = out_valid_o ? mem_q[rd_q] : last_q;
    assign overflow_o = ovf_q;
    assign cnt_wrap_o = wrap_q;
endmodule
